// File: rtl/delay_predictor_mac.sv
// ----------------------------------------------------------------------------
// delay_predictor_mac
//
// N-tap fixed-point delay-line predictor with one shared multiply-accumulate
// unit. For every accepted sample the block forms
//     se = sat(round(sum_k c[k] * d[k]))
// over the stored history d[] (d[0] is the newest sample). It then shifts the
// accepted sample into the history. One tap is processed per clock.
// Throughput is one sample per ORDER+3 cycles at best.
//
// Optional feature:
//   DLYPRED_CLR_EN - adds input dl_clr. When dl_clr is high while the block
//                    is idle, the delay line is zeroed on the next edge. If an
//                    accept happens on the same edge, the clear applies first:
//                    the prediction is 0 and the new sample is shifted into a
//                    clean history. Coefficients are not touched.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous, active-low reset
//   in_valid   sample offered on in_dq
//   in_ready   high only while idle
//   in_dq      input sample (two's complement, DATA_W)
//   coef_wr    write coef_data into shadow coefficient coef_addr
//   coef_addr  shadow coefficient index; values >= ORDER are ignored
//   coef_data  coefficient (two's complement, FRAC fractional bits)
//   out_valid  prediction available
//   out_ready  consumer takes the prediction
//   out_se     prediction; holds its value until the next rounding step
//   out_sat    prediction was clipped to the DATA_W range
//   busy       block is not idle
//   scan_en    DFT scan enable (used by scan insertion only)
//   scan_in0   DFT scan input
//   scan_out0  DFT scan output, tied low in RTL
//   dl_clr     (DLYPRED_CLR_EN only) clear the delay line while idle
// ----------------------------------------------------------------------------
module delay_predictor_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ORDER  = 6,
    parameter int FRAC   = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_dq,
    input  logic                       coef_wr,
    input  logic [$clog2(ORDER)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_se,
    output logic                       out_sat,
    output logic                       busy,
    input  logic                       scan_en,
    input  logic                       scan_in0,
`ifdef DLYPRED_CLR_EN
    output logic                       scan_out0,
    input  logic                       dl_clr
`else
    output logic                       scan_out0
`endif
);

    localparam int AW    = $clog2(ORDER);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + $clog2(ORDER);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] RND  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    localparam logic [AW-1:0]           K_LAST   = AW'(ORDER - 1);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    // Round half up, then drop the fractional bits with an arithmetic shift.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        return (a + RND_HALF) >>> FRAC;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (a < SAT_MIN) begin
            return {1'b1, SAT_MIN[DATA_W-1:0]};
        end
        return {1'b0, a[DATA_W-1:0]};
    endfunction

    logic [1:0]               state;
    logic [AW-1:0]            k;
    logic signed [DATA_W-1:0] samp_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [DATA_W-1:0] d     [ORDER];
    logic signed [COEF_W-1:0] c_shd [ORDER];
    logic signed [COEF_W-1:0] c_act [ORDER];

    logic signed [PW-1:0]     d_ext;
    logic signed [PW-1:0]     c_ext;
    logic signed [PW-1:0]     prod_p1;

    logic                     unused_scan;

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign scan_out0   = 1'b0;
    assign unused_scan = scan_en ^ scan_in0;

    // Shared multiplier for tap k. Both operands are sign-extended to the full
    // product width, so the product is exact.
    always_comb begin
        d_ext   = PW'(d[k]);
        c_ext   = PW'(c_act[k]);
        prod_p1 = d_ext * c_ext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= '0;
            samp_p0   <= '0;
            acc_p1    <= '0;
            out_valid <= 1'b0;
            out_se    <= '0;
            out_sat   <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                d[i]     <= '0;
                c_shd[i] <= '0;
                c_act[i] <= '0;
            end
        end else begin
            // Shadow writes never stall. An accept on the same edge copies the old value.
            if (coef_wr && (int'(coef_addr) < ORDER)) begin
                c_shd[coef_addr] <= coef_data;
            end

            case (state)
                // Stage p0: accept the sample and freeze the coefficient set.
                IDLE: begin
`ifdef DLYPRED_CLR_EN
                    if (dl_clr) begin
                        for (int i = 0; i < ORDER; i++) begin
                            d[i] <= '0;
                        end
                    end
`endif
                    if (in_valid) begin
                        samp_p0 <= in_dq;
                        for (int i = 0; i < ORDER; i++) begin
                            c_act[i] <= c_shd[i];
                        end
                        acc_p1 <= '0;
                        k      <= '0;
                        state  <= MAC;
                    end
                end

                // Stage p1: one tap per cycle over the history before this sample.
                MAC: begin
                    acc_p1 <= acc_p1 + ACC_W'(prod_p1);
                    k      <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= RND;
                    end
                end

                // Stage p2: round, clip and register the result, then shift the sample in.
                RND: begin
                    {out_sat, out_se} <= saturate(round_shift(acc_p1));
                    for (int i = ORDER - 1; i > 0; i--) begin
                        d[i] <= d[i-1];
                    end
                    d[0]      <= samp_p0;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
